// File: rtl/sh7034_pkg.sv
// Shared SH7034 package: SCI sync-peer defaults and status bundle.
package sh7034_pkg;

  localparam logic [7:0] SCI_PEER_FILL_DEF = 8'hFF;

  typedef struct packed {
    logic rx_ovr;
    logic rx_empty;
    logic tx_full;
  } sci_peer_status_t;

endpackage

// File: rtl/sh7034_sci_peer_fifo.sv
// Byte-wide synchronous show-ahead FIFO used for the sync peer's RX and TX paths.
module sh7034_sci_peer_fifo #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] data,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  do_push;
  logic                  do_pop;

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop    = ce & pop & ~empty;
    do_push   = ce & push & (~full | do_pop);
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (do_pop && !do_push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= count_nxt[DEPTH_LOG2];
      empty <= (count_nxt == '0);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sh7034_sci_sync_peer.sv
// Clocked-synchronous far-end peer for the SH7034 SCI (SCKO/TXD in, RXD out).
// Optional loopback of received bytes into the TX FIFO: define SCI_PEER_LOOPBACK_EN.
module sh7034_sci_sync_peer
  import sh7034_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter logic [7:0]  FILL       = SCI_PEER_FILL_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
`ifdef SCI_PEER_LOOPBACK_EN
  input  logic       LOOP,
`endif
  input  logic       SCK,
  input  logic       SDI,
  output logic       SDO,
  input  logic       SYNC,
  input  logic [7:0] TX_DATA,
  input  logic       TX_WR,
  output logic       TX_FULL,
  output logic [7:0] RX_DATA,
  input  logic       RX_RD,
  output logic       RX_EMPTY,
  output logic       RX_OVR,
  input  logic       RX_OVR_CLR,
  output logic       BYTE_DONE
);

  logic [2:0] sck_sync;
  logic [2:0] sdi_sync;
  logic [7:0] rsr;
  logic [7:0] tsr;
  logic [2:0] bit_cnt;
  logic       sdo_r;
  logic       byte_pend;
  logic       edge_seen;
  logic       tsr_is_fill;
  logic       byte_done_r;
  logic       rx_ovr_r;

  logic       rise;
  logic       fall;
  logic       rx_push;
  logic       rx_full;
  logic       rx_empty;
  logic       overrun;
  logic       idle_load;
  logic       tx_push;
  logic [7:0] tx_data;
  logic       tx_pop;
  logic       tx_full;
  logic       tx_empty;
  logic [7:0] tx_head;
  logic [7:0] next_byte;

  sci_peer_status_t status;

  always_comb begin
    rise      = sck_sync[1] & ~sck_sync[2];
    fall      = ~sck_sync[1] & sck_sync[2];
    rx_push   = byte_pend & ~SYNC;
    overrun   = rx_push & rx_full & ~(RX_RD & ~rx_empty);
    // Replace an idle FILL with real data only before the first edge of the next byte.
    idle_load = ~byte_pend & ~SYNC & ~rise & ~fall & (bit_cnt == 3'd0) &
                ~edge_seen & tsr_is_fill & ~tx_empty;
    tx_pop    = rx_push | idle_load;
    next_byte = tx_empty ? FILL : tx_head;
    tx_push   = TX_WR;
    tx_data   = TX_DATA;
`ifdef SCI_PEER_LOOPBACK_EN
    if (LOOP && rx_push) begin
      tx_push = 1'b1;
      tx_data = rsr;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sck_sync    <= '1;
      sdi_sync    <= '1;
      rsr         <= '0;
      tsr         <= FILL;
      bit_cnt     <= '0;
      sdo_r       <= 1'b1;
      byte_pend   <= 1'b0;
      edge_seen   <= 1'b0;
      tsr_is_fill <= 1'b1;
      byte_done_r <= 1'b0;
      rx_ovr_r    <= 1'b0;
    end else if (CE) begin
      sck_sync    <= {sck_sync[1:0], SCK};
      sdi_sync    <= {sdi_sync[1:0], SDI};
      byte_done_r <= rx_push;
      rx_ovr_r    <= overrun | (rx_ovr_r & ~RX_OVR_CLR);
      if (SYNC) begin
        rsr         <= '0;
        tsr         <= FILL;
        bit_cnt     <= '0;
        sdo_r       <= 1'b1;
        byte_pend   <= 1'b0;
        edge_seen   <= 1'b0;
        tsr_is_fill <= 1'b1;
      end else if (byte_pend) begin
        byte_pend   <= 1'b0;
        edge_seen   <= 1'b0;
        tsr         <= next_byte;
        sdo_r       <= next_byte[0];
        tsr_is_fill <= tx_empty;
      end else if (rise) begin
        rsr       <= {sdi_sync[2], rsr[7:1]};
        bit_cnt   <= bit_cnt + 1'b1;
        byte_pend <= (bit_cnt == 3'd7);
        edge_seen <= 1'b1;
      end else if (fall) begin
        edge_seen <= 1'b1;
        // Bit 0 is already on the line from the boundary load; later falls advance.
        if (bit_cnt != 3'd0) begin
          tsr   <= {1'b0, tsr[7:1]};
          sdo_r <= tsr[1];
        end
      end else if (idle_load) begin
        tsr         <= tx_head;
        sdo_r       <= tx_head[0];
        tsr_is_fill <= 1'b0;
      end
    end
  end

  sh7034_sci_peer_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (CLK),
    .rst   (RST),
    .ce    (CE),
    .push  (rx_push),
    .pop   (RX_RD),
    .data  (rsr),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (RX_DATA)
  );

  sh7034_sci_peer_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (CLK),
    .rst   (RST),
    .ce    (CE),
    .push  (tx_push),
    .pop   (tx_pop),
    .data  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  assign status    = '{rx_ovr: rx_ovr_r, rx_empty: rx_empty, tx_full: tx_full};
  assign RX_OVR    = status.rx_ovr;
  assign RX_EMPTY  = status.rx_empty;
  assign TX_FULL   = status.tx_full;
  assign SDO       = sdo_r;
  assign BYTE_DONE = byte_done_r;

endmodule
